// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the 7-segment scan driver.
//   Glyph codes are active-high, bit 6 = segment a .. bit 0 = segment g.
//   Hex letters use the lowercase/compact forms the board can render:
//   A='t', B='n', C='d', D='r', E='h', F='E'.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions inside a glyph
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h72;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h0F;
    localparam logic [6:0] GLYPH_B = 7'h15;
    localparam logic [6:0] GLYPH_C = 7'h3D;
    localparam logic [6:0] GLYPH_D = 7'h05;
    localparam logic [6:0] GLYPH_E = 7'h17;
    localparam logic [6:0] GLYPH_F = 7'h4F;

endpackage

// File: rtl/seg7_glyph_rom.sv
// -----------------------------------------------------------------------------
// seg7_glyph_rom
//   Combinational nibble -> active-high 7-segment glyph lookup.
//   Ports:
//     code   in  4  display code 0..F
//     glyph  out 7  active-high segments, bit6=a .. bit0=g
// -----------------------------------------------------------------------------
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit 7-segment display with a
//   double-buffered image, per-digit blank/dp/blink and leading-zero
//   suppression. Digit 0 is rightmost.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     load_i                capture strobe for value/blank/dp/blink/lzs
//     value_i [4*N]         nibble k = code for digit k
//     blank_i/dp_i/blink_i  per-digit dark / decimal point / blink enables
//     lzs_i                 leading-zero suppression enable
//     pending_o             pending image not yet displayed
//     frame_o               1-cycle pulse as the digit-0 slot starts
//     seg_o [7], dp_o       segments (bit6=a..bit0=g) and decimal point
//     an_o [N]              digit enables
//   Handshake: load_i is a single-cycle strobe with no backpressure; every
//   cycle it is high is accepted, the last one before a frame boundary wins.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_i,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blink_i,
    input  logic                      lzs_i,
    output logic                      pending_o,
    output logic                      frame_o,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD   = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // XOR masks turning active-high "lit" into pin levels; also the reset/off level
    localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    // Scan state
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Active (displayed) and pending image
    logic [NUM_DIGITS-1:0][3:0] act_val,   pend_val;
    logic [NUM_DIGITS-1:0]      act_blank, pend_blank;
    logic [NUM_DIGITS-1:0]      act_dp,    pend_dp;
    logic [NUM_DIGITS-1:0]      act_blink, pend_blink;
    logic                       act_lzs,   pend_lzs;

    logic boundary;
    assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Slot / digit / blink counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (boundary) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: active only changes on the frame boundary, so a frame
    // is never a mix of two images. A load landing on the boundary bypasses
    // the pending buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_val    <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
            act_blink  <= '0;
            act_lzs    <= 1'b0;
            pend_val   <= '0;
            pend_blank <= '1;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_lzs   <= 1'b0;
            pending_o  <= 1'b0;
        end else if (boundary) begin
            pending_o <= 1'b0;
            if (load_i) begin
                act_val   <= value_i;
                act_blank <= blank_i;
                act_dp    <= dp_i;
                act_blink <= blink_i;
                act_lzs   <= lzs_i;
            end else if (pending_o) begin
                act_val   <= pend_val;
                act_blank <= pend_blank;
                act_dp    <= pend_dp;
                act_blink <= pend_blink;
                act_lzs   <= pend_lzs;
            end
        end else if (load_i) begin
            pend_val   <= value_i;
            pend_blank <= blank_i;
            pend_dp    <= dp_i;
            pend_blink <= blink_i;
            pend_lzs   <= lzs_i;
            pending_o  <= 1'b1;
        end
    end

    // Leading-zero mask: walk from the leftmost digit; zeros are suppressed
    // until a digit that is both nonzero and not blanked. Digit 0 is never
    // suppressed so a zero value still shows '0'.
    logic [NUM_DIGITS-1:0] lzs_mask;
    logic                  leading;
    always_comb begin
        lzs_mask = '0;
        leading  = act_lzs;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (leading && (act_val[k] == 4'h0)) lzs_mask[k] = 1'b1;
            if ((act_val[k] != 4'h0) && !act_blank[k]) leading = 1'b0;
        end
    end

    // Current digit decode
    logic [6:0] glyph;
    seg7_glyph_rom u_rom (
        .code  (act_val[idx]),
        .glyph (glyph)
    );

    logic                  blinked;
    logic                  dark;
    logic [6:0]            seg_lit;
    logic                  dp_lit;
    logic [NUM_DIGITS-1:0] an_lit;

    always_comb begin
        blinked = act_blink[idx] & phase;
        dark    = act_blank[idx] | blinked | lzs_mask[idx];
        seg_lit = dark ? SEG_BLANK : glyph;
        // A suppressed leading zero keeps its dp; blank and blink kill it
        dp_lit  = act_dp[idx] & ~act_blank[idx] & ~blinked;
        an_lit  = '0;
        if (cnt >= CNT_DEAD) an_lit[idx] = 1'b1;
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_o   <= SEG_OFF;
            dp_o    <= DP_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_lit ^ SEG_OFF;
            dp_o    <= dp_lit ^ DP_OFF;
            an_o    <= an_lit ^ AN_OFF;
            frame_o <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8,
//   DEAD_CYCLES=2, BLINK_FRAMES=2, active-low segments, active-high anodes.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 2;
    localparam int BF = 2;

    logic          clk;
    logic          reset_n;
    logic          load_i;
    logic [15:0]   value_i;
    logic [3:0]    blank_i;
    logic [3:0]    dp_i;
    logic [3:0]    blink_i;
    logic          lzs_i;
    logic          pending_o;
    logic          frame_o;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    an_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .DEAD_CYCLES  (DC),
        .BLINK_FRAMES (BF),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load_i),
        .value_i   (value_i),
        .blank_i   (blank_i),
        .dp_i      (dp_i),
        .blink_i   (blink_i),
        .lzs_i     (lzs_i),
        .pending_o (pending_o),
        .frame_o   (frame_o),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .an_o      (an_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one load strobe, starting and ending on a falling edge
    task automatic drive_load(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dp,
                              input logic [3:0] bk, input logic lz);
        value_i = v;
        blank_i = bl;
        dp_i    = dp;
        blink_i = bk;
        lzs_i   = lz;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    // Returns at a falling edge where frame_o is high (possibly the current one)
    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (frame_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_frame"}, 32'(seen), 32'd1);
    endtask

    // Check one full scan frame. exp_lit packs active-high glyphs with digit 0
    // in bits [6:0]; exp_dp is active-high dp per digit. Ends on the next
    // frame_o cycle so frames can be checked back to back.
    task automatic check_frame(input string tag, input logic [27:0] exp_lit, input logic [3:0] exp_dp);
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        wait_frame(tag);
        for (int k = 0; k < ND; k++) begin
            for (int c = 0; c < RD; c++) begin
                @(negedge clk);
                if (c == 0) check({tag, "_dead"}, 32'(an_o), 32'd0);
                if (c == DC) begin
                    es = ~exp_lit[k*7 +: 7];
                    ea = 4'(1 << k);
                    ed = ~exp_dp[k];
                    check({tag, "_an"},  32'(an_o),  32'(ea));
                    check({tag, "_seg"}, 32'(seg_o), 32'(es));
                    check({tag, "_dp"},  32'(dp_o),  32'(ed));
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        load_i  = 1'b0;
        value_i = '0;
        blank_i = '0;
        dp_i    = '0;
        blink_i = '0;
        lzs_i   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_seg",  32'(seg_o),     32'h7F);
        check("rst_dp",   32'(dp_o),      32'd1);
        check("rst_an",   32'(an_o),      32'd0);
        check("rst_pend", 32'(pending_o), 32'd0);
        check("rst_frm",  32'(frame_o),   32'd0);
        reset_n = 1'b1;

        // No load: anodes scan, everything dark
        check_frame("idle", 28'h0, 4'h0);

        // 1234: pending until the boundary, old (dark) image meanwhile
        drive_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        check("pend_set", 32'(pending_o), 32'd1);
        @(negedge clk);
        check("no_tear", 32'(seg_o), 32'h7F);
        check_frame("d1234", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0);
        check("pend_clr", 32'(pending_o), 32'd0);

        // Code sweep
        drive_load(16'hFEDC, 4'h0, 4'h0, 4'h0, 1'b0);
        check_frame("dFEDC", {7'h4F, 7'h17, 7'h05, 7'h3D}, 4'h0);
        drive_load(16'hBA98, 4'h0, 4'b0101, 4'h0, 1'b0);
        check_frame("dBA98", {7'h15, 7'h0F, 7'h7B, 7'h7F}, 4'b0101);

        // Leading-zero suppression; suppressed digit 3 keeps its dp
        drive_load(16'h0040, 4'h0, 4'b1000, 4'h0, 1'b1);
        check_frame("lzs40", {7'h00, 7'h00, 7'h33, 7'h7E}, 4'b1000);
        drive_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
        check_frame("lzs0", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'h0);

        // Blank kills both segments and dp of digit 2
        drive_load(16'h1234, 4'b0100, 4'b0110, 4'h0, 1'b0);
        check_frame("blank", {7'h30, 7'h00, 7'h79, 7'h33}, 4'b0010);

        // Repeated loads before the boundary: last wins
        repeat (5) @(negedge clk);
        drive_load(16'h5555, 4'h0, 4'h0, 4'h0, 1'b0);
        drive_load(16'h6789, 4'h0, 4'h0, 4'h0, 1'b0);
        check("last_pend", 32'(pending_o), 32'd1);
        check_frame("last", {7'h5F, 7'h72, 7'h7F, 7'h7B}, 4'h0);

        // Load exactly on the boundary cycle goes straight to active
        repeat (RD * ND - 1) @(negedge clk);
        drive_load(16'h0F0F, 4'h0, 4'h0, 4'h0, 1'b0);
        check("bnd_frame", 32'(frame_o),   32'd1);
        check("bnd_pend",  32'(pending_o), 32'd0);
        check_frame("bnd", {7'h7E, 7'h4F, 7'h7E, 7'h4F}, 4'h0);

        // Reset mid-frame with data pending: immediate off, pending discarded
        repeat (10) @(negedge clk);
        drive_load(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0);
        check("mid_pend", 32'(pending_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mrst_seg",  32'(seg_o),     32'h7F);
        check("mrst_dp",   32'(dp_o),      32'd1);
        check("mrst_an",   32'(an_o),      32'd0);
        check("mrst_pend", 32'(pending_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_frame("post_rst", 28'h0, 4'h0);
        check("post_pend", 32'(pending_o), 32'd0);

        // Blink with a fresh blink counter: lit, dark, dark, lit
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_load(16'h1234, 4'h0, 4'b0011, 4'b0001, 1'b0);
        check_frame("blk1", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0011);
        check_frame("blk2", {7'h30, 7'h6D, 7'h79, 7'h00}, 4'b0010);
        check_frame("blk3", {7'h30, 7'h6D, 7'h79, 7'h00}, 4'b0010);
        check_frame("blk4", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0011);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
